// File: rtl/braun_pkg.sv
// Shared constants and helpers for the pipelined Braun array multiplier.
package braun_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 16;

  // Number of array-group register stages.
  function automatic int unsigned nstg(input int unsigned width,
                                       input int unsigned rows_per_stage);
    return (width - 1 + rows_per_stage - 1) / rows_per_stage;
  endfunction

  // Register stages from acceptance to out_valid: input reg, groups, output reg.
  function automatic int unsigned latency(input int unsigned width,
                                          input int unsigned rows_per_stage);
    return nstg(width, rows_per_stage) + 2;
  endfunction

  // 1-based group that evaluates carry-save row `row` (rows start at 1).
  function automatic int unsigned row_group(input int unsigned row,
                                            input int unsigned rows_per_stage);
    return (row - 1) / rows_per_stage + 1;
  endfunction

  // Last carry-save row evaluated by group `grp`.
  function automatic int unsigned last_row(input int unsigned grp, input int unsigned width,
                                           input int unsigned rows_per_stage);
    int unsigned r;
    r = grp * rows_per_stage;
    return (r < width - 1) ? r : width - 1;
  endfunction

endpackage

// File: rtl/braun_mult_pipe_if.sv
// Operand/product stream interface of the Braun multiplier.
interface braun_mult_pipe_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic                 busy;

  // Environment side: operand source and product consumer.
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product, busy
  );

  // Multiplier side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product, busy
  );
endinterface

// File: rtl/braun_csa_row.sv
// One carry-save row of the Braun array: partial products a & b_i added to the
// incoming sum/carry vectors. s_i/c_i bit j carries the same weight as pp[j].
module braun_csa_row #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             b_i,
  input  logic [WIDTH-2:0] s_i,
  input  logic [WIDTH-2:0] c_i,
  output logic [WIDTH-2:0] s_o,
  output logic [WIDTH-2:0] c_o,
  output logic             p_o
);
  logic [WIDTH-1:0] pp;
  logic [WIDTH-2:0] sum;

  assign pp = a_i & {WIDTH{b_i}};

  for (genvar j = 0; j < WIDTH - 1; j++) begin : g_fa
    full_adder u_fa (
      .a_i  (pp[j]),
      .b_i  (s_i[j]),
      .ci_i (c_i[j]),
      .s_o  (sum[j]),
      .co_o (c_o[j])
    );
  end

  // Lowest sum bit is final; the rest shift down one weight, the top pp enters.
  assign p_o = sum[0];
  if (WIDTH > 2) begin : g_shift
    assign s_o = {pp[WIDTH-1], sum[WIDTH-2:1]};
  end else begin : g_narrow
    assign s_o = pp[WIDTH-1];
  end
endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule

// File: rtl/braun_mult_pipe.sv
// Pipelined unsigned Braun array multiplier with globally stalled valid/ready pipe.
module braun_mult_pipe
  import braun_pkg::*;
#(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned ROWS_PER_STAGE = WIDTH - 1
) (
  input logic              clk,
  input logic              rst_n,
  braun_mult_pipe_if.slave bus
);
  localparam int unsigned NSTG = nstg(WIDTH, ROWS_PER_STAGE);

  logic adv;

  // Stage g register feeds group g+1; a/b are not needed after the last group.
  logic [WIDTH-1:0]   a_q  [NSTG];
  logic [WIDTH-1:0]   a_d  [NSTG];
  logic [WIDTH-1:1]   b_q  [NSTG];
  logic [WIDTH-1:1]   b_d  [NSTG];
  logic [WIDTH-2:0]   s_q  [NSTG+1];
  logic [WIDTH-2:0]   s_d  [NSTG+1];
  logic [WIDTH-2:0]   c_q  [NSTG+1];
  logic [WIDTH-2:0]   c_d  [NSTG+1];
  logic [WIDTH-1:0]   lo_q [NSTG+1];
  logic [WIDTH-1:0]   lo_d [NSTG+1];
  logic [NSTG:0]      vld_q;
  logic               out_valid_q;
  logic [2*WIDTH-1:0] out_product_q;
  logic [2*WIDTH-1:0] product_d;

  logic [WIDTH-2:0]   row_s [1:WIDTH-1];
  logic [WIDTH-2:0]   row_c [1:WIDTH-1];
  logic [WIDTH-1:1]   row_p;
  logic [WIDTH-2:0]   rip_s;
  logic [WIDTH-1:0]   rip_c;

  assign adv             = ~out_valid_q | bus.out_ready;
  assign bus.in_ready    = adv;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_product = out_product_q;
  assign bus.busy        = |vld_q | out_valid_q;

  // Carry-save rows 1..WIDTH-1; the first row of each group reads the stage register.
  for (genvar i = 1; i < WIDTH; i++) begin : g_row
    localparam int unsigned Src = row_group(i, ROWS_PER_STAGE) - 1;
    logic [WIDTH-2:0] s_in;
    logic [WIDTH-2:0] c_in;
    if ((i - 1) % ROWS_PER_STAGE == 0) begin : g_first
      assign s_in = s_q[Src];
      assign c_in = c_q[Src];
    end else begin : g_chain
      assign s_in = row_s[i-1];
      assign c_in = row_c[i-1];
    end
    braun_csa_row #(
      .WIDTH (WIDTH)
    ) u_row (
      .a_i (a_q[Src]),
      .b_i (b_q[Src][i]),
      .s_i (s_in),
      .c_i (c_in),
      .s_o (row_s[i]),
      .c_o (row_c[i]),
      .p_o (row_p[i])
    );
  end

  // Final ripple-carry row resolves the upper WIDTH bits.
  assign rip_c[0] = 1'b0;
  for (genvar j = 0; j < WIDTH - 1; j++) begin : g_rip
    full_adder u_fa (
      .a_i  (s_q[NSTG][j]),
      .b_i  (c_q[NSTG][j]),
      .ci_i (rip_c[j]),
      .s_o  (rip_s[j]),
      .co_o (rip_c[j+1])
    );
  end
  assign product_d = {rip_c[WIDTH-1], rip_s, lo_q[NSTG]};

  // Next-state data for every stage register: row 0 at the input, groups after.
  always_comb begin
    a_d[0]     = bus.in_a;
    b_d[0]     = bus.in_b[WIDTH-1:1];
    s_d[0]     = bus.in_a[WIDTH-1:1] & {(WIDTH-1){bus.in_b[0]}};
    c_d[0]     = '0;
    lo_d[0]    = '0;
    lo_d[0][0] = bus.in_a[0] & bus.in_b[0];
    for (int unsigned g = 1; g < NSTG; g++) begin
      a_d[g] = a_q[g-1];
      b_d[g] = b_q[g-1];
    end
    for (int unsigned g = 1; g <= NSTG; g++) begin
      s_d[g]     = row_s[last_row(g, WIDTH, ROWS_PER_STAGE)];
      c_d[g]     = row_c[last_row(g, WIDTH, ROWS_PER_STAGE)];
      lo_d[g][0] = lo_q[g-1][0];
      for (int unsigned k = 1; k < WIDTH; k++) begin
        if (row_group(k, ROWS_PER_STAGE) == g) lo_d[g][k] = row_p[k];
        else                                   lo_d[g][k] = lo_q[g-1][k];
      end
    end
  end

  // Pipeline registers: everything advances together on adv, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned g = 0; g < NSTG; g++) begin
        a_q[g] <= '0;
        b_q[g] <= '0;
      end
      for (int unsigned g = 0; g <= NSTG; g++) begin
        s_q[g]  <= '0;
        c_q[g]  <= '0;
        lo_q[g] <= '0;
      end
      vld_q         <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
    end else if (adv) begin
      for (int unsigned g = 0; g < NSTG; g++) begin
        a_q[g] <= a_d[g];
        b_q[g] <= b_d[g];
      end
      for (int unsigned g = 0; g <= NSTG; g++) begin
        s_q[g]  <= s_d[g];
        c_q[g]  <= c_d[g];
        lo_q[g] <= lo_d[g];
      end
      // in_ready equals adv, so in_valid alone marks an accepted operand pair.
      vld_q         <= {vld_q[NSTG-1:0], bus.in_valid};
      out_valid_q   <= vld_q[NSTG];
      out_product_q <= product_d;
    end
  end
endmodule
